// File: rtl/deslocador_multiciclo.sv
// Multi-mode shift/rotate register: parallel load, then bit-serial shift by a programmable distance.
// Optional macro DESLOC_ROTATE_EN enables rotate codes 100/101; otherwise they behave as HOLD.
//
// state | meaning
// IDLE  | waiting for load or start; accepts one of them per cycle, load wins
// SHIFT | one shift step per clock until the step counter reaches its last step
// DONE  | operation finished; done is raised on the following edge, then back to IDLE

module deslocador_multiciclo #(
    parameter  int size  = 8,
    localparam int AMT_W = $clog2(size) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [size-1:0]    E,
    input  logic               start,
    input  logic [2:0]         mode,
    input  logic [AMT_W-1:0]   amt,
    input  logic               Er,
    input  logic               El,
    output logic [size-1:0]    Y,
    output logic               sout,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [AMT_W-1:0] SIZE_AMT = AMT_W'(size);
    localparam logic [AMT_W-1:0] ONE_AMT  = AMT_W'(1);

    state_t           state;
    logic [AMT_W-1:0] cnt;
    logic [2:0]       mode_q;
    logic [AMT_W-1:0] amt_sat;

    // Distances beyond the word width saturate, so a full rotate returns the word.
    always_comb begin
        amt_sat = amt;
        if (amt > SIZE_AMT)
            amt_sat = SIZE_AMT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            Y      <= '0;
            sout   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            cnt    <= '0;
            mode_q <= 3'b000;
        end else begin
            // done lags the DONE state by one edge and never overlaps busy.
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (load) begin
                        Y <= E;
                    end else if (start) begin
                        mode_q <= mode;
                        cnt    <= amt_sat;
                        if (amt == '0) begin
                            state <= DONE;
                        end else begin
                            state <= SHIFT;
                            busy  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    case (mode_q)
                        3'b000: begin
                            Y    <= {Y[size-2:0], Er};
                            sout <= Y[size-1];
                        end
                        3'b001: begin
                            Y    <= {El, Y[size-1:1]};
                            sout <= Y[0];
                        end
                        3'b010: begin
                            Y    <= {Y[size-1], Y[size-1:1]};
                            sout <= Y[0];
                        end
`ifdef DESLOC_ROTATE_EN
                        3'b100: begin
                            Y    <= {Y[size-2:0], Y[size-1]};
                            sout <= Y[size-1];
                        end
                        3'b101: begin
                            Y    <= {Y[0], Y[size-1:1]};
                            sout <= Y[0];
                        end
`endif
                        default: begin
                            Y    <= Y;
                            sout <= sout;
                        end
                    endcase
                    cnt <= cnt - ONE_AMT;
                    if (cnt == ONE_AMT) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deslocador_multiciclo.sv
// Self-checking bench for deslocador_multiciclo (size=8): directed cases plus randomized
// operations against an arithmetic word-level reference model.

module tb_deslocador_multiciclo;

    localparam int SIZE  = 8;
    localparam int AMT_W = $clog2(SIZE) + 1;
    localparam int MASK  = (1 << SIZE) - 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               load;
    logic [SIZE-1:0]    E;
    logic               start;
    logic [2:0]         mode;
    logic [AMT_W-1:0]   amt;
    logic               Er;
    logic               El;
    logic [SIZE-1:0]    Y;
    logic               sout;
    logic               busy;
    logic               done;

    int vectors    = 0;
    int miscompares = 0;

    int m = 0;   // model word
    int s = 0;   // model ejected bit

    deslocador_multiciclo #(.size(SIZE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .E     (E),
        .start (start),
        .mode  (mode),
        .amt   (amt),
        .Er    (Er),
        .El    (El),
        .Y     (Y),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One shift step computed from the word value with plain arithmetic.
    task automatic mstep(input int md, input int er, input int el);
        int msb;
        int lsb;
        msb = (m >> (SIZE - 1)) & 1;
        lsb = m & 1;
        case (md)
            0: begin s = msb; m = ((m * 2) + er) & MASK; end
            1: begin s = lsb; m = (m / 2) + (el << (SIZE - 1)); end
            2: begin s = lsb; m = (m / 2) + (msb << (SIZE - 1)); end
`ifdef DESLOC_ROTATE_EN
            4: begin s = msb; m = ((m * 2) + msb) & MASK; end
            5: begin s = lsb; m = (m / 2) + (lsb << (SIZE - 1)); end
`endif
            default: ;
        endcase
    endtask

    task automatic do_load(input int val, input bit with_start);
        load  = 1'b1;
        E     = SIZE'(val);
        start = with_start;
        mode  = 3'($urandom_range(0, 7));
        amt   = AMT_W'($urandom_range(1, 15));
        tick();
        m = val & MASK;
        chk("load_y", Y, m);
        chk("load_busy", busy, 0);
        load  = 1'b0;
        start = 1'b0;
        tick();
        chk("load_nobusy", busy, 0);
        chk("load_nodone", done, 0);
        chk("load_hold_y", Y, m);
    endtask

    // er_v/el_v: 0 or 1 forces the fill bit, 2 randomizes it every step.
    task automatic run_op(input int md, input int amt_v, input int er_v, input int el_v, input bit noisy);
        int n;
        int er;
        int el;
        n = (amt_v > SIZE) ? SIZE : amt_v;
        mode  = 3'(md);
        amt   = AMT_W'(amt_v);
        start = 1'b1;
        load  = 1'b0;
        tick();
        start = 1'b0;
        mode  = 3'($urandom_range(0, 7));
        amt   = AMT_W'($urandom_range(0, 15));
        chk("start_busy", busy, (n > 0) ? 1 : 0);
        chk("start_done", done, 0);
        for (int i = 1; i <= n; i++) begin
            er = (er_v == 2) ? int'($urandom_range(0, 1)) : er_v;
            el = (el_v == 2) ? int'($urandom_range(0, 1)) : el_v;
            Er = er[0];
            El = el[0];
            if (noisy) begin
                load  = $urandom_range(0, 1) != 0;
                start = $urandom_range(0, 1) != 0;
                E     = SIZE'($urandom);
            end
            tick();
            mstep(md, er, el);
            chk("step_y", Y, m);
            chk("step_sout", sout, s);
            chk("step_busy", busy, (i < n) ? 1 : 0);
            chk("step_done", done, 0);
        end
        load  = noisy;
        start = noisy;
        E     = '1;
        tick();
        load  = 1'b0;
        start = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_y", Y, m);
        tick();
        chk("done_clear", done, 0);
        chk("idle_y", Y, m);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        start = 1'b0;
        E     = '0;
        mode  = 3'b000;
        amt   = '0;
        Er    = 1'b0;
        El    = 1'b0;
        #12;
        chk("rst_y", Y, 0);
        chk("rst_sout", sout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // SHL with Er=1 on A5
        do_load('hA5, 1'b0);
        run_op(0, 3, 1, 0, 1'b0);
        chk("shl_final", Y, 'h2F);
        chk("shl_sout", sout, 1);

        // SAR and SHR on 90
        do_load('h90, 1'b0);
        run_op(2, 2, 0, 0, 1'b0);
        chk("sar_final", Y, 'hE4);
        do_load('h90, 1'b0);
        run_op(1, 2, 0, 0, 1'b0);
        chk("shr_final", Y, 'h24);

        // rotates (HOLD without the rotate macro)
        do_load('h81, 1'b0);
        run_op(5, 1, 0, 0, 1'b0);
`ifdef DESLOC_ROTATE_EN
        chk("ror_final", Y, 'hC0);
        chk("ror_sout", sout, 1);
`else
        chk("ror_hold", Y, 'h81);
`endif
        do_load('h81, 1'b0);
        run_op(4, 9, 0, 0, 1'b0);
        chk("rol9_final", Y, 'h81);

        // amt=0, load beats start, busy-time commands ignored
        do_load('h3C, 1'b0);
        run_op(0, 0, 1, 1, 1'b0);
        chk("amt0_y", Y, 'h3C);
        do_load('h5A, 1'b1);
        do_load('h66, 1'b0);
        run_op(1, 4, 2, 2, 1'b1);

        // asynchronous reset in the middle of a shift
        do_load('hC3, 1'b0);
        mode  = 3'b000;
        amt   = AMT_W'(5);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_y", Y, 0);
        chk("arst_sout", sout, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        m = 0;
        s = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_load('hA5, 1'b0);
        run_op(0, 3, 1, 0, 1'b0);
        chk("post_rst_final", Y, 'h2F);

        // randomized operations
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 2) == 0)
                do_load(int'($urandom_range(0, MASK)), $urandom_range(0, 1) != 0);
            run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 2, 2,
                   $urandom_range(0, 1) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

endmodule
